// File: rtl/morse_tx_engine.sv
`default_nettype none
// ============================================================================
// morse_tx_engine : ASCII character FIFO feeding a ROM-driven Morse keyer.
// Optional pause input enabled by defining MORSE_PAUSE_EN.   Rev 1.0
// ============================================================================
module morse_tx_engine #(
  parameter int UNIT_CYCLES = 5000000,
  parameter int FIFO_DEPTH  = 16,
  parameter int CODE_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic [7:0]                    rom_addr,
  input  logic [CODE_WIDTH-1:0]         rom_data,
  output logic                          key,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          ovf
`ifdef MORSE_PAUSE_EN
  ,
  input  logic                          pause
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(7 * UNIT_CYCLES);
  localparam logic [TW-1:0] T_1U = TW'(UNIT_CYCLES - 1);
  localparam logic [TW-1:0] T_3U = TW'(3 * UNIT_CYCLES - 1);
  localparam logic [TW-1:0] T_7U = TW'(7 * UNIT_CYCLES - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    LOAD     = 3'd2,
    MARK     = 3'd3,
    SPACE    = 3'd4,
    CHAR_GAP = 3'd5,
    WORD_GAP = 3'd6
  } state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          run;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;
  logic          timer_done;
  logic [11:0]   shift;
  logic [11:0]   shift_nxt;
  logic [3:0]    left;
  logic [3:0]    left_nxt;
  logic [3:0]    raw_len;
  logic [3:0]    len;

`ifdef MORSE_PAUSE_EN
  assign run = ~pause;
`else
  assign run = 1'b1;
`endif

  assign full       = (count == FULL_COUNT);
  assign empty      = (count == '0);
  assign in_ready   = ~full;
  assign push       = in_valid & ~full;
  assign fifo_count = count;
  assign busy       = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Sticky until reset; the offered character is simply dropped.
      if (in_valid && full) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  assign raw_len    = rom_data[15:12];
  assign len        = (raw_len > 4'd12) ? 4'd12 : raw_len;
  assign timer_done = (timer == '0);

  always_comb begin
    state_nxt = state;
    shift_nxt = shift;
    left_nxt  = left;
    pop       = 1'b0;
    if (run) begin
      case (state)
        IDLE: begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = FETCH;
          end
        end
        FETCH: state_nxt = LOAD;
        LOAD: begin
          if (len == 4'd0) begin
            state_nxt = WORD_GAP;
          end else begin
            state_nxt = MARK;
            shift_nxt = rom_data[11:0];
            left_nxt  = len;
          end
        end
        MARK: begin
          if (timer_done) begin
            shift_nxt = {shift[10:0], 1'b0};
            left_nxt  = left - 1'b1;
            state_nxt = (left > 4'd1) ? SPACE : CHAR_GAP;
          end
        end
        SPACE:    if (timer_done) state_nxt = MARK;
        CHAR_GAP: if (timer_done) state_nxt = IDLE;
        WORD_GAP: if (timer_done) state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // Timer is reloaded on every state entry, so each state's length is its load value + 1.
  always_comb begin
    timer_nxt = timer;
    if (state_nxt != state) begin
      case (state_nxt)
        MARK:     timer_nxt = shift_nxt[11] ? T_3U : T_1U;
        SPACE:    timer_nxt = T_1U;
        CHAR_GAP: timer_nxt = T_3U;
        WORD_GAP: timer_nxt = T_7U;
        default:  timer_nxt = '0;
      endcase
    end else if (run && !timer_done) begin
      timer_nxt = timer - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      shift    <= '0;
      left     <= '0;
      key      <= 1'b0;
      rom_addr <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      shift <= shift_nxt;
      left  <= left_nxt;
      key   <= (state_nxt == MARK);
      if (pop) rom_addr <= mem[rd_ptr];
    end
  end

endmodule
`default_nettype wire
